// File: rtl/udm_bus_arb.sv
// Two-master arbiter for the UART debug master slave bus with an in-order read-owner FIFO.
// Define BUS_ARB_FIXED_PRIO_EN for fixed m0 priority; round-robin otherwise.
module udm_bus_arb #(
  parameter int RD_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_bo,
  output logic [31:0] bus_wdata_bo,
  input  logic        bus_ack_i,
  input  logic        bus_resp_i,
  input  logic [31:0] bus_rdata_bi,
  output logic        resp_err_o
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RD_DEPTH);

  logic          r_owner;
  logic          r_locked;
  logic          r_fifo [RD_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_resp_err;

  logic w_full;
  logic w_elig0;
  logic w_elig1;
  logic w_sel;
  logic w_sel_vld;
  logic w_xfer;
  logic w_push;
  logic w_pop;
  logic w_head;

  // A read cannot be granted while every FIFO slot holds an outstanding owner.
  assign w_full  = (r_count == FULL);
  assign w_elig0 = m0_req_i & (m0_we_i | ~w_full);
  assign w_elig1 = m1_req_i & (m1_we_i | ~w_full);

`ifndef BUS_ARB_FIXED_PRIO_EN
  logic r_rr_last;
`endif

  always_comb begin
    w_sel     = 1'b0;
    w_sel_vld = 1'b0;
    if (r_locked) begin
      w_sel     = r_owner;
      w_sel_vld = r_owner ? w_elig1 : w_elig0;
    end else if (w_elig0 && w_elig1) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
      w_sel     = 1'b0;
`else
      w_sel     = ~r_rr_last;
`endif
      w_sel_vld = 1'b1;
    end else if (w_elig0) begin
      w_sel_vld = 1'b1;
    end else if (w_elig1) begin
      w_sel     = 1'b1;
      w_sel_vld = 1'b1;
    end
    if (rst_i) begin
      w_sel_vld = 1'b0;
    end
  end

  assign bus_req_o    = w_sel_vld;
  assign bus_we_o     = w_sel_vld & (w_sel ? m1_we_i : m0_we_i);
  assign bus_addr_bo  = w_sel_vld ? (w_sel ? m1_addr_bi  : m0_addr_bi)  : 32'h0;
  assign bus_wdata_bo = w_sel_vld ? (w_sel ? m1_wdata_bi : m0_wdata_bi) : 32'h0;

  assign w_xfer   = w_sel_vld & bus_ack_i;
  assign m0_ack_o = w_xfer & ~w_sel;
  assign m1_ack_o = w_xfer &  w_sel;

  // A response pops only entries pushed on earlier edges, never a same-cycle push.
  assign w_push      = w_xfer & ~bus_we_o;
  assign w_pop       = bus_resp_i & (r_count != '0) & ~rst_i;
  assign w_head      = r_fifo[r_rd_ptr];
  assign m0_resp_o   = w_pop & ~w_head;
  assign m1_resp_o   = w_pop &  w_head;
  assign m0_rdata_bo = bus_rdata_bi;
  assign m1_rdata_bo = bus_rdata_bi;
  assign resp_err_o  = r_resp_err;

  // Grant lock: hold the selected master until the slave accepts it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_locked <= 1'b0;
      r_owner  <= 1'b0;
    end else if (w_sel_vld && !bus_ack_i) begin
      r_locked <= 1'b1;
      r_owner  <= w_sel;
    end else begin
      r_locked <= 1'b0;
    end
  end

`ifndef BUS_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_last <= 1'b1;
    end else if (w_xfer) begin
      r_rr_last <= w_sel;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus_resp_i && (r_count == '0)) begin
        r_resp_err <= 1'b1;
      end
    end
  end

endmodule
